// File: rtl/pipeline_exec_ctrl.sv
// Execution sequencer for the 5-stage MIPS pipeline: owns the global stall line and
// pipeline-reset pulse, runs free-run / single-step / reset, drains and parks on HALT.
module pipeline_exec_ctrl #(
    parameter int              SIZE         = 32,
    parameter logic [SIZE-1:0] HALT_OPCODE  = 32'hFFFF_FFFF,
    parameter int              DRAIN_CYCLES = 4,
    parameter int              PRST_CYCLES  = 2,
    parameter int              CNT_SIZE     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cmd_valid,
    input  logic [1:0]          i_cmd,
    output logic                o_cmd_ready,
    input  logic [SIZE-1:0]     i_if_instruction,
    output logic                o_stall,
    output logic                o_pipe_rst,
    output logic                o_busy,
    output logic                o_done,
    output logic [2:0]          o_state,
    output logic [CNT_SIZE-1:0] o_cycle_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam int PW = (PRST_CYCLES > 1) ? $clog2(PRST_CYCLES + 1) : 1;

    localparam logic [1:0] CMD_PRST = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_HALT = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4,
        PRST  = 3'd5
    } state_t;

    state_t                state_reg, state_next;
    logic [DW-1:0]         drain_cnt_reg;
    logic [PW-1:0]         prst_cnt_reg;
    logic [CNT_SIZE-1:0]   cycle_count_reg;
    logic                  cmd_fire;
    logic                  halt_fetched;
    logic                  enter_drain;
    logic                  enter_prst;

    assign cmd_fire     = i_cmd_valid && o_cmd_ready;
    assign halt_fetched = (i_if_instruction == HALT_OPCODE);
    assign enter_drain  = (state_next == DRAIN) && (state_reg != DRAIN);
    assign enter_prst   = (state_next == PRST) && (state_reg != PRST);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    unique case (i_cmd)
                        CMD_RUN:  state_next = RUN;
                        CMD_STEP: state_next = STEP;
                        CMD_PRST: state_next = PRST;
                        CMD_HALT: state_next = IDLE;
                    endcase
                end
            end
            // Program end takes priority over a host pause in the same cycle.
            RUN: begin
                if (halt_fetched)
                    state_next = DRAIN;
                else if (cmd_fire && i_cmd == CMD_HALT)
                    state_next = IDLE;
            end
            STEP:  state_next = halt_fetched ? DRAIN : IDLE;
            DRAIN: if (drain_cnt_reg <= DW'(1)) state_next = DONE;
            DONE:  if (cmd_fire && i_cmd == CMD_PRST) state_next = PRST;
            PRST:  if (prst_cnt_reg <= PW'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            drain_cnt_reg   <= '0;
            prst_cnt_reg    <= '0;
            cycle_count_reg <= '0;
        end else begin
            state_reg <= state_next;

            if (enter_drain)
                drain_cnt_reg <= DW'(DRAIN_CYCLES);
            else if (state_reg == DRAIN)
                drain_cnt_reg <= drain_cnt_reg - DW'(1);

            if (enter_prst)
                prst_cnt_reg <= PW'(PRST_CYCLES);
            else if (state_reg == PRST)
                prst_cnt_reg <= prst_cnt_reg - PW'(1);

            // Saturating count of executed cycles; cleared when a pipeline reset begins.
            if (enter_prst)
                cycle_count_reg <= '0;
            else if (!o_stall && cycle_count_reg != {CNT_SIZE{1'b1}})
                cycle_count_reg <= cycle_count_reg + CNT_SIZE'(1);
        end
    end

    assign o_stall       = !(state_reg == RUN || state_reg == STEP || state_reg == DRAIN);
    assign o_cmd_ready   = (state_reg == IDLE) || (state_reg == RUN) || (state_reg == DONE);
    assign o_busy        = (state_reg == RUN) || (state_reg == STEP) ||
                           (state_reg == DRAIN) || (state_reg == PRST);
    assign o_done        = (state_reg == DONE);
    assign o_pipe_rst    = (state_reg == PRST);
    assign o_state       = state_reg;
    assign o_cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// Scoreboard bench for pipeline_exec_ctrl: stimulus queues expected snapshots,
// a monitor pops and compares them against the DUT outputs.
module tb_pipeline_exec_ctrl;

    localparam logic [31:0] HALT_OP = 32'hFFFF_FFFF;
    localparam logic [1:0]  C_PRST = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_HALT = 2'b11;
    localparam int S_IDLE = 0, S_RUN = 1, S_STEP = 2, S_DRAIN = 3, S_DONE = 4, S_PRST = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic [31:0] instr = 32'h0;
    logic        cmd_ready, stall, pipe_rst, busy, done;
    logic [2:0]  state;
    logic [31:0] count;

    logic        sat_valid = 1'b0;
    logic [1:0]  sat_cmd = 2'b00;
    logic [31:0] sat_instr = 32'h0;
    logic        sat_ready, sat_stall, sat_pipe_rst, sat_busy, sat_done;
    logic [2:0]  sat_state;
    logic [3:0]  sat_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          unit;
        int          st;
        bit          stall, ready, done, busy, prst;
        int          cnt;
    } exp_t;

    exp_t exp_q[$];
    event sample_ev;

    always #5 clk = ~clk;

    pipeline_exec_ctrl u_dut (
        .clk(clk), .rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(cmd_ready),
        .i_if_instruction(instr), .o_stall(stall), .o_pipe_rst(pipe_rst), .o_busy(busy),
        .o_done(done), .o_state(state), .o_cycle_count(count)
    );

    pipeline_exec_ctrl #(.CNT_SIZE(4)) u_sat (
        .clk(clk), .rst(rst), .i_cmd_valid(sat_valid), .i_cmd(sat_cmd), .o_cmd_ready(sat_ready),
        .i_if_instruction(sat_instr), .o_stall(sat_stall), .o_pipe_rst(sat_pipe_rst),
        .o_busy(sat_busy), .o_done(sat_done), .o_state(sat_state), .o_cycle_count(sat_count)
    );

    // Monitor: compares every queued expectation at the falling edge (or on demand).
    initial begin
        forever begin
            @(negedge clk or sample_ev);
            while (exp_q.size() > 0) begin
                exp_t e;
                int a_st, a_cnt;
                bit a_stall, a_ready, a_done, a_busy, a_prst;
                e = exp_q.pop_front();
                if (e.unit) begin
                    a_st = int'(sat_state); a_stall = sat_stall; a_ready = sat_ready;
                    a_done = sat_done; a_busy = sat_busy; a_prst = sat_pipe_rst; a_cnt = int'(sat_count);
                end else begin
                    a_st = int'(state); a_stall = stall; a_ready = cmd_ready;
                    a_done = done; a_busy = busy; a_prst = pipe_rst; a_cnt = int'(count);
                end
                checks++;
                if (a_st != e.st || a_stall != e.stall || a_ready != e.ready || a_done != e.done ||
                    a_busy != e.busy || a_prst != e.prst || a_cnt != e.cnt) begin
                    errors++;
                    $display("FAIL %s: got state=%0d stall=%0b ready=%0b done=%0b busy=%0b prst=%0b count=%0d, expected state=%0d stall=%0b ready=%0b done=%0b busy=%0b prst=%0b count=%0d",
                             e.name, a_st, a_stall, a_ready, a_done, a_busy, a_prst, a_cnt,
                             e.st, e.stall, e.ready, e.done, e.busy, e.prst, e.cnt);
                end else begin
                    $display("check %s: state=%0d count=%0d ok", e.name, a_st, a_cnt);
                end
            end
        end
    end

    task automatic expect_out(input string nm, input bit u, input int st, input bit stl,
                              input bit rdy, input bit dn, input bit bsy, input bit prs, input int cnt);
        exp_t e;
        e.name = nm; e.unit = u; e.st = st; e.stall = stl; e.ready = rdy;
        e.done = dn; e.busy = bsy; e.prst = prs; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the command until ready, let it be accepted, return one step past that edge.
    task automatic send_cmd(input logic [1:0] c);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd = c;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: ready stayed %0b, required 1 within 50 cycles", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick(); tick();
        expect_out("reset", 0, S_IDLE, 1, 1, 0, 0, 0, 0);
        expect_out("reset_sat", 1, S_IDLE, 1, 1, 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        // Free-run to HALT: 11 RUN cycles + 4 DRAIN cycles
        instr = 32'h0000_0020;
        send_cmd(C_RUN);
        for (int i = 1; i <= 10; i++) begin
            expect_out("run", 0, S_RUN, 0, 1, 0, 1, 0, i - 1);
            tick();
        end
        instr = HALT_OP;
        expect_out("run_halt_fetch", 0, S_RUN, 0, 1, 0, 1, 0, 10);
        tick();
        instr = 32'h0;
        for (int d = 1; d <= 4; d++) begin
            expect_out("drain", 0, S_DRAIN, 0, 0, 0, 1, 0, 10 + d);
            tick();
        end
        expect_out("done", 0, S_DONE, 1, 1, 1, 0, 0, 15);

        // DONE ignores RUN; PRESET pulses pipe reset for 2 cycles and clears count
        send_cmd(C_RUN);
        expect_out("done_ignore_run", 0, S_DONE, 1, 1, 1, 0, 0, 15);
        send_cmd(C_PRST);
        expect_out("prst_c1", 0, S_PRST, 1, 0, 0, 1, 1, 0);
        tick();
        expect_out("prst_c2", 0, S_PRST, 1, 0, 0, 1, 1, 0);
        tick();
        expect_out("prst_idle", 0, S_IDLE, 1, 1, 0, 0, 0, 0);

        // Three single steps
        for (int k = 0; k < 3; k++) begin
            send_cmd(C_STEP);
            expect_out("step", 0, S_STEP, 0, 0, 0, 1, 0, k);
            tick();
            expect_out("step_idle", 0, S_IDLE, 1, 1, 0, 0, 0, k + 1);
        end

        // Pause / resume
        send_cmd(C_PRST);
        tick(); tick();
        expect_out("prst_before_pause", 0, S_IDLE, 1, 1, 0, 0, 0, 0);
        send_cmd(C_RUN);
        for (int i = 1; i <= 4; i++) tick();
        expect_out("run_c5", 0, S_RUN, 0, 1, 0, 1, 0, 4);
        send_cmd(C_HALT);
        expect_out("pause1", 0, S_IDLE, 1, 1, 0, 0, 0, 5);
        send_cmd(C_RUN);
        tick(); tick();
        send_cmd(C_HALT);
        expect_out("pause2", 0, S_IDLE, 1, 1, 0, 0, 0, 8);

        // HALT opcode and HALT command in the same RUN cycle
        send_cmd(C_RUN);
        instr = HALT_OP;
        send_cmd(C_HALT);
        instr = 32'h0;
        for (int d = 0; d < 4; d++) begin
            expect_out("simul_drain", 0, S_DRAIN, 0, 0, 0, 1, 0, 9 + d);
            tick();
        end
        expect_out("simul_done", 0, S_DONE, 1, 1, 1, 0, 0, 13);

        // Asynchronous reset in the middle of DRAIN
        send_cmd(C_PRST);
        tick(); tick();
        send_cmd(C_RUN);
        instr = HALT_OP;
        tick();
        instr = 32'h0;
        tick();
        expect_out("pre_async_drain", 0, S_DRAIN, 0, 0, 0, 1, 0, 2);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        expect_out("async_rst", 0, S_IDLE, 1, 1, 0, 0, 0, 0);
        -> sample_ev;
        tick();
        rst = 1'b0;

        // Saturation on the 4-bit counter instance
        sat_cmd = C_RUN;
        sat_valid = 1'b1;
        tick();
        sat_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        expect_out("sat_15", 1, S_RUN, 0, 1, 0, 1, 0, 15);
        for (int i = 0; i < 5; i++) tick();
        expect_out("sat_hold", 1, S_RUN, 0, 1, 0, 1, 0, 15);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_exec_ctrl.md
Name: pipeline_exec_ctrl

Overview:
Execution sequencer for the 5-stage mips pipeline. It owns the pipeline's global i_stall line and a pipeline-reset pulse, and runs the core in one of three modes: free-run, single-step or pipeline reset. It accepts commands through a valid/ready handshake from the debug/host side. It detects the HALT instruction at the fetch output, drains the pipeline so older instructions retire, then parks the core and counts executed (unstalled) cycles.

Parameters:
SIZE, 32, instruction width
HALT_OPCODE, 32'hFFFFFFFF, instruction word that terminates a program
DRAIN_CYCLES, 4, unstalled cycles after HALT fetch so ID/EX/MEM/WB retire
PRST_CYCLES, 2, cycles o_pipe_rst is held high
CNT_SIZE, 32, executed-cycle counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
i_cmd_valid  in  1  command strobe
i_cmd  in  2  00 PRESET (pipeline reset), 01 RUN, 10 STEP, 11 HALT (pause)
o_cmd_ready  out  1  command accepted on clock edge when i_cmd_valid && o_cmd_ready
i_if_instruction  in  SIZE  instruction at instruction_fetch output
o_stall  out  1  drives mips i_stall (1 = frozen)
o_pipe_rst  out  1  synchronous reset request to pipeline latches/PC
o_busy  out  1  state in {RUN, STEP, DRAIN, PRST}
o_done  out  1  level, HALT retired, core parked
o_state  out  3  IDLE=0 RUN=1 STEP=2 DRAIN=3 DONE=4 PRST=5
o_cycle_count  out  CNT_SIZE  cycles with o_stall=0 since last PRST/rst

Behaviour:
- Moore outputs decoded from registered state. Command accepted at edge t takes effect from cycle t+1.
- Reset (async, any state): state=IDLE, o_stall=1, o_pipe_rst=0, o_done=0, o_busy=0, o_cmd_ready=1, o_cycle_count=0, drain/prst counters=0.
- o_stall=0 only in RUN, STEP, DRAIN. o_cmd_ready=1 in IDLE, RUN, DONE. 0 in STEP, DRAIN, PRST.
- IDLE: RUN->RUN. STEP->STEP. PRST->PRST. HALT consumed, no effect.
- RUN: If i_if_instruction==HALT_OPCODE, go to DRAIN and load drain counter with DRAIN_CYCLES. Otherwise a HALT cmd goes to IDLE (pause, resumable). RUN/STEP/PRST cmds are consumed and ignored.
- STEP: lasts exactly one cycle. Goes to DRAIN if HALT_OPCODE is fetched that cycle, else to IDLE.
- DRAIN: the drain counter decrements each cycle and the state stays DRAIN_CYCLES cycles. Goes to DONE when the counter reads 1. The HALT_OPCODE compare is ignored here. Instructions fetched after HALT are padded with NOPs by software.
- DONE: o_done=1, o_stall=1. Only PRST acts (goes to PRST). RUN/STEP/HALT are consumed and ignored.
- PRST: o_pipe_rst=1, o_stall=1 for PRST_CYCLES cycles. o_cycle_count is cleared on entry. Then goes to IDLE.
- Counter: +1 on every cycle with o_stall=0. Saturates at all-ones (no wrap).
- Simultaneous events: HALT opcode and HALT cmd in the same RUN cycle resolve to DRAIN (program end wins). A cmd presented while ready=0 is held by the requester and not lost.
- rst asserted mid-DRAIN/PRST aborts immediately. o_pipe_rst drops asynchronously.

Test Plan:
- rst, RUN; non-HALT words for 10 RUN cycles, HALT_OPCODE on the 11th -> o_stall=0 for 15 cycles (11 RUN + 4 DRAIN), then o_done=1, o_stall=1, o_cycle_count=15, o_state=4.
- Three STEP cmds, each accepted when ready -> three single-cycle o_stall=0 pulses with IDLE in between, o_cmd_ready=0 during each STEP cycle, count=3.
- RUN, HALT cmd accepted after 5 RUN cycles -> IDLE, count=5, o_stall=1. RUN again for 3 cycles then HALT -> count=8.
- In DONE, RUN cmd -> no state change, o_done stays 1. PRST cmd -> o_pipe_rst=1 for exactly 2 cycles, count=0, then IDLE with o_done=0.
- In RUN, HALT cmd and HALT_OPCODE on the same cycle -> DRAIN (o_state=3) for 4 cycles, then DONE. Separately, with CNT_SIZE=4, RUN 20 cycles -> count holds 15.
- Assert rst asynchronously mid-DRAIN (between clock edges) -> o_state=0, o_stall=1, o_busy=0, count=0 before the next edge.
